// File: rtl/fm_readout_sched.sv
// Feature-map readout scheduler: sweeps kernel-select inner / address outer and
// delays issue strobes by RD_LAT to drive the accumulators. Optional stall: FM_SCHED_STALL_EN.
module fm_readout_sched #(
    parameter int NUM_KERNELS = 4,
    parameter int FM_DEPTH    = 64,
    parameter int ADDR_W      = 6,
    parameter int SEL_W       = 2,
    parameter int RD_LAT      = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [SEL_W-1:0]  ram_select,
    output logic              acc_en,
    output logic              acc_clr,
    output logic              busy,
    output logic              product_rdy
);

`ifdef FM_SCHED_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FM_DEPTH - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_KERNELS - 1);

    // state | meaning
    // IDLE  | waiting for start with armed set
    // SWEEP | issuing one beat per unstalled cycle
    // DRAIN | last beat issued, waiting for its acc_en
    // DONE  | product_rdy pulse
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic              armed;
    logic              launch;
    logic              issue;
    logic              first_beat;
    logic              last_beat;
    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] clr_sr;
    logic [RD_LAT-1:0] last_sr;

    assign first_beat = (rd_addr == '0) && (ram_select == '0);
    assign last_beat  = (rd_addr == ADDR_LAST) && (ram_select == SEL_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start && armed) begin
                    state_nxt = SWEEP;
                    launch    = 1'b1;
                end
            end
            SWEEP: begin
                issue = !(STALL_EN && stall);
                if (issue && last_beat) state_nxt = DRAIN;
            end
            DRAIN:   if (last_sr[RD_LAT-1]) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // armed needs a low start seen in IDLE, so a held start cannot retrigger
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       armed <= 1'b1;
        else if (launch)                  armed <= 1'b0;
        else if (state == IDLE && !start) armed <= 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_addr    <= '0;
            ram_select <= '0;
        end else if (launch) begin
            rd_addr    <= '0;
            ram_select <= '0;
        end else if (issue && !last_beat) begin
            if (ram_select == SEL_LAST) begin
                ram_select <= '0;
                rd_addr    <= rd_addr + ADDR_W'(1);
            end else begin
                ram_select <= ram_select + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_sr  <= '0;
            clr_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr  <= (vld_sr << 1)  | RD_LAT'(issue);
            clr_sr  <= (clr_sr << 1)  | RD_LAT'(issue && first_beat);
            last_sr <= (last_sr << 1) | RD_LAT'(issue && last_beat);
        end
    end

    assign acc_en      = vld_sr[RD_LAT-1];
    assign acc_clr     = clr_sr[RD_LAT-1];
    assign busy        = (state != IDLE);
    assign product_rdy = (state == DONE);

endmodule

// File: tb/tb_fm_readout_sched.sv
// Bench for fm_readout_sched: two configurations (4x8 lat 2, 3x5 lat 1), run table plus
// hand-written hold-high, retrigger and mid-run reset sequences.
module tb_fm_readout_sched;

`ifdef FM_SCHED_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct packed {
        logic       busy;
        logic       acc_en;
        logic       acc_clr;
        logic       rdy;
        logic [2:0] addr;
        logic [1:0] sel;
    } obs_t;

    typedef struct {
        int dut;
        int sf;
        int st;
        int exp_rdy;
        int exp_acc;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start_a, stall_a, start_b, stall_b;
    logic [2:0] addr_a, addr_b;
    logic [1:0] sel_a, sel_b;
    logic       acc_en_a, acc_clr_a, busy_a, rdy_a;
    logic       acc_en_b, acc_clr_b, busy_b, rdy_b;

    int checks   = 0;
    int failures = 0;
    obs_t sb[$];
    vec_t vecs[5];

    fm_readout_sched #(.NUM_KERNELS(4), .FM_DEPTH(8), .ADDR_W(3), .SEL_W(2), .RD_LAT(2)) u_a (
        .clock(clk), .reset(rst_n), .start(start_a), .stall(stall_a),
        .rd_addr(addr_a), .ram_select(sel_a), .acc_en(acc_en_a), .acc_clr(acc_clr_a),
        .busy(busy_a), .product_rdy(rdy_a)
    );

    fm_readout_sched #(.NUM_KERNELS(3), .FM_DEPTH(5), .ADDR_W(3), .SEL_W(2), .RD_LAT(1)) u_b (
        .clock(clk), .reset(rst_n), .start(start_b), .stall(stall_b),
        .rd_addr(addr_b), .ram_select(sel_b), .acc_en(acc_en_b), .acc_clr(acc_clr_b),
        .busy(busy_b), .product_rdy(rdy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t sample(input int dut);
        obs_t o;
        if (dut == 0) o = '{busy_a, acc_en_a, acc_clr_a, rdy_a, addr_a, sel_a};
        else          o = '{busy_b, acc_en_b, acc_clr_b, rdy_b, addr_b, sel_b};
        return o;
    endfunction

    task automatic drive(input int dut, input logic st, input logic sl);
        if (dut == 0) begin start_a = st; stall_a = sl; end
        else          begin start_b = st; stall_b = sl; end
    endtask

    task automatic check_obs(input string name, input int t, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual busy=%b acc_en=%b acc_clr=%b rdy=%b addr=%0d sel=%0d required busy=%b acc_en=%b acc_clr=%b rdy=%b addr=%0d sel=%0d",
                     name, t, act.busy, act.acc_en, act.acc_clr, act.rdy, act.addr, act.sel,
                     exp.busy, exp.acc_en, exp.acc_clr, exp.rdy, exp.addr, exp.sel);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One run: build the expected timeline, push it, then pop/compare cycle by cycle.
    task automatic run_case(input int idx, input int dut, input int sf, input int st,
                            input int exp_rdy, input int exp_acc);
        int nk, dp, lat, nb, n, t, last_iss, first_iss, rdy_t, b, obs_rdy, obs_acc;
        int   beat_at[128];
        bit   issued_at[128];
        obs_t e, a;
        nk  = (dut == 0) ? 4 : 3;
        dp  = (dut == 0) ? 8 : 5;
        lat = (dut == 0) ? 2 : 1;
        nb  = nk * dp;
        for (int i = 0; i < 128; i++) begin beat_at[i] = 0; issued_at[i] = 1'b0; end
        n = 0; t = 1; last_iss = 0; first_iss = 0;
        while (n < nb) begin
            beat_at[t]   = n;
            issued_at[t] = !(STALL_EN && t >= sf && t <= st);
            if (issued_at[t]) begin
                if (n == 0) first_iss = t;
                n++;
                last_iss = t;
            end
            t++;
        end
        rdy_t = last_iss + lat + 1;
        for (int tt = 1; tt <= rdy_t + 3; tt++) begin
            b         = (tt <= last_iss) ? beat_at[tt] : nb - 1;
            e.busy    = (tt <= rdy_t);
            e.rdy     = (tt == rdy_t);
            e.acc_en  = (tt - lat >= 1) && issued_at[tt - lat];
            e.acc_clr = (tt == first_iss + lat);
            e.addr    = 3'(b / nk);
            e.sel     = 2'(b % nk);
            sb.push_back(e);
        end

        drive(dut, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(dut, 1'b1, 1'b0);
        obs_rdy = -1; obs_acc = 0;
        for (int tt = 1; tt <= rdy_t + 3; tt++) begin
            @(posedge clk); #1;
            drive(dut, 1'b1, (tt >= sf && tt <= st));
            a = sample(dut);
            if (a.rdy && obs_rdy < 0) obs_rdy = tt;
            if (a.acc_en) obs_acc++;
            e = sb.pop_front();
            check_obs($sformatf("run%0d_cycle", idx), tt, a, e);
        end
        drive(dut, 1'b1, 1'b0);
        check_int($sformatf("run%0d_rdy_offset", idx), obs_rdy, exp_rdy);
        check_int($sformatf("run%0d_acc_count", idx), obs_acc, exp_acc);
    endtask

    initial begin
        int rdy_cnt, busy_cnt;
        vecs[0] = '{0, 0, -1, 35, 32};
        vecs[1] = '{0, 5, 7, STALL_EN ? 38 : 35, 32};
        vecs[2] = '{0, 1, 2, STALL_EN ? 37 : 35, 32};
        vecs[3] = '{0, 31, 34, STALL_EN ? 39 : 35, 32};
        vecs[4] = '{1, 0, -1, 17, 15};

        rst_n = 1'b0;
        start_a = 1'b0; stall_a = 1'b0; start_b = 1'b0; stall_b = 1'b0;
        #3;
        check_obs("reset_a", 0, sample(0), '0);
        check_obs("reset_b", 0, sample(1), '0);
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++)
            run_case(i, vecs[i].dut, vecs[i].sf, vecs[i].st, vecs[i].exp_rdy, vecs[i].exp_acc);

        // start held high for 100 cycles yields a single run
        drive(0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0);
        rdy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (rdy_a) rdy_cnt++;
        end
        check_int("hold_high_rdy_count", rdy_cnt, 1);
        check_int("hold_high_idle_busy", int'(busy_a), 0);

        // one low cycle re-arms; raising start again begins a second run
        drive(0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_int("retrigger_busy", int'(busy_a), 1);
        check_int("retrigger_addr_sel", {29'd0, addr_a, sel_a} , 0);
        for (int i = 0; i < 40; i++) @(posedge clk);
        #1;

        // mid-run reset: outputs clear without a clock edge, run abandoned
        drive(0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        check_int("pre_reset_busy", int'(busy_a), 1);
        #1;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0);
        #1;
        check_obs("async_reset_a", 10, sample(0), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (rdy_a)  rdy_cnt++;
            if (busy_a) busy_cnt++;
        end
        check_int("post_reset_rdy_count", rdy_cnt, 0);
        check_int("post_reset_busy_count", busy_cnt, 0);

        run_case(5, 0, 0, -1, 35, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
